// File: rtl/fluid_board_soc_nios2_qsys_0_oci_dct_packer.sv
// DCT trace packer: folds 2-bit direct-control-transfer codes into a
// 15-code accumulator and hands full/flushed packets to a holding register.
module fluid_board_soc_nios2_qsys_0_oci_dct_packer #(
  parameter int DCT_DEPTH        = 15,
  parameter bit FLUSH_ON_DISABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_enable,
  input  logic        dct_code_valid,
  input  logic [1:0]  dct_code,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [33:0] pkt_data,
  output logic        overflow,
  output logic [7:0]  drop_count,
  input  logic        overflow_clr
);

  localparam logic [3:0] FULL = 4'(DCT_DEPTH);

  logic        flush_pend;
  logic        prev_enable;
  logic        acc;
  logic        drop;
  logic        flush_req;
  logic        emit;
  logic        hold_free;
  logic [29:0] next_buf;
  logic [3:0]  next_cnt;

  // Accept/drop decision, next accumulator value and emit conditions.
  always_comb begin
    next_buf  = dct_buffer;
    next_cnt  = dct_count;
    drop      = 1'b0;
    acc       = dct_code_valid && trace_enable && (dct_code != 2'b00);
    if (acc) begin
      if (dct_count != FULL) begin
        next_buf = {dct_buffer[27:0], dct_code};
        next_cnt = dct_count + 4'd1;
      end else begin
        drop = 1'b1;
      end
    end
    flush_req = flush || flush_pend ||
                (FLUSH_ON_DISABLE && prev_enable && !trace_enable);
    emit      = (next_cnt == FULL) ||
                (flush_req && (next_cnt != 4'd0));
    hold_free = !pkt_valid || pkt_ready;
  end

  // Accumulator, holding register and pending-flush state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer  <= '0;
      dct_count   <= '0;
      pkt_valid   <= 1'b0;
      pkt_data    <= '0;
      flush_pend  <= 1'b0;
      prev_enable <= 1'b0;
    end else begin
      prev_enable <= trace_enable;
      if (emit && hold_free) begin
        pkt_data   <= {next_cnt, next_buf};
        pkt_valid  <= 1'b1;
        dct_buffer <= '0;
        dct_count  <= '0;
        flush_pend <= 1'b0;
      end else if (emit) begin
        dct_buffer <= next_buf;
        dct_count  <= next_cnt;
        flush_pend <= flush_req;
      end else begin
        dct_buffer <= next_buf;
        dct_count  <= next_cnt;
        pkt_valid  <= pkt_valid && !pkt_ready;
        flush_pend <= 1'b0;
      end
    end
  end

  // Sticky overflow and saturating drop counter; clear wins over a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fluid_board_soc_nios2_qsys_0_oci_dct_packer.sv
// Bench for the DCT packer: directed scenarios plus a randomized run
// against a queue-based packet model.
module tb_fluid_board_soc_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trace_enable = 1'b0;
  logic        dct_code_valid = 1'b0;
  logic [1:0]  dct_code = 2'b00;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [33:0] pkt_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        overflow_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  fluid_board_soc_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk),
    .reset(reset),
    .trace_enable(trace_enable),
    .dct_code_valid(dct_code_valid),
    .dct_code(dct_code),
    .flush(flush),
    .dct_buffer(dct_buffer),
    .dct_count(dct_count),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_data(pkt_data),
    .overflow(overflow),
    .drop_count(drop_count),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Reference model: codes held as a queue, packet as a value.
  int          mq[$];
  bit          m_valid;
  logic [33:0] m_data;
  bit          m_pend;
  bit          m_prev;
  bit          m_ovf;
  int          m_drops;

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] b = '0;
    foreach (q[i]) b = (b << 2) | 30'(q[i]);
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 0;
    m_data  = '0;
    m_pend  = 0;
    m_prev  = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic model_edge();
    bit acc, freq, emit, free;
    int nq[$];
    acc = dct_code_valid && trace_enable && dct_code != 2'b00;
    nq = mq;
    if (acc && nq.size() < 15) nq.push_back(int'(dct_code));
    if (overflow_clr) begin
      m_ovf = 0;
      m_drops = 0;
    end else if (acc && mq.size() == 15) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    freq = flush || m_pend || (m_prev && !trace_enable);
    emit = nq.size() == 15 || (freq && nq.size() != 0);
    free = !m_valid || pkt_ready;
    if (emit && free) begin
      m_data  = {4'(nq.size()), pack(nq)};
      m_valid = 1;
      mq.delete();
      m_pend  = 0;
    end else if (emit) begin
      mq = nq;
      m_pend = freq;
    end else begin
      mq = nq;
      m_valid = m_valid && !pkt_ready;
      m_pend = 0;
    end
    m_prev = trace_enable;
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic en,
                      input logic fl, input logic rdy, input logic clr);
    dct_code_valid = v;
    dct_code       = c;
    trace_enable   = en;
    flush          = fl;
    pkt_ready      = rdy;
    overflow_clr   = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dct_code_valid = 0; dct_code = 0; trace_enable = 0;
    flush = 0; pkt_ready = 0; overflow_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dct_buffer, dct_count, pkt_valid, pkt_data, overflow, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got buf=%h cnt=%0d v=%b data=%h ovf=%b drops=%0d, want all 0",
               dct_buffer, dct_count, pkt_valid, pkt_data, overflow, drop_count);
    end
  endtask

  task automatic test_full_packet();
    logic [33:0] exp;
    exp = {4'd15, 30'h15555555};
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 2'b01, 1, 0, 1, 0);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_data !== exp || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL full_packet: got v=%b data=%h cnt=%0d, want v=1 data=%h cnt=0",
               pkt_valid, pkt_data, dct_count, exp);
    end
  endtask

  task automatic test_back_to_back();
    int pkts = 0;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      step(1, 2'($urandom_range(1, 3)), 1, 0, 1, 0);
      if (pkt_valid) pkts++;
      checks++;
      if (pkt_valid !== m_valid || pkt_data !== m_data) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got v=%b data=%h, want v=%b data=%h",
                 i, pkt_valid, pkt_data, m_valid, m_data);
      end
    end
    checks++;
    if (pkts !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d packets, want 3", pkts);
    end
  endtask

  task automatic test_flush();
    logic [33:0] exp;
    exp = {4'd3, 30'h0000001B};
    do_reset();
    step(1, 2'b01, 1, 0, 1, 0);
    step(1, 2'b10, 1, 0, 1, 0);
    step(1, 2'b11, 1, 0, 1, 0);
    checks++;
    if (dct_count !== 4'd3 || dct_buffer !== 30'h1B || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accum: got cnt=%0d buf=%h v=%b, want cnt=3 buf=1b v=0",
               dct_count, dct_buffer, pkt_valid);
    end
    step(0, 2'b00, 1, 1, 1, 0);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_data !== exp || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL flush_partial: got v=%b data=%h cnt=%0d, want v=1 data=%h cnt=0",
               pkt_valid, pkt_data, dct_count, exp);
    end
    step(0, 2'b00, 1, 0, 1, 0);
    step(0, 2'b00, 1, 1, 1, 0);
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got v=%b, want v=0", pkt_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] first, second;
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 2'b01, 1, 0, 0, 0);
    first = {4'd15, 30'h15555555};
    for (int i = 0; i < 16; i++) step(1, 2'($urandom_range(1, 3)), 1, 0, 0, 0);
    second = {4'd15, pack(mq)};
    checks++;
    if (dct_count !== 4'd15 || overflow !== 1'b1 || drop_count !== 8'd1 ||
        pkt_valid !== 1'b1 || pkt_data !== first) begin
      errors++;
      $display("FAIL bp_full: got cnt=%0d ovf=%b drops=%0d v=%b data=%h, want 15 1 1 1 %h",
               dct_count, overflow, drop_count, pkt_valid, pkt_data, first);
    end
    step(0, 2'b00, 1, 0, 1, 0);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_data !== second || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL bp_reload: got v=%b data=%h cnt=%0d, want v=1 data=%h cnt=0",
               pkt_valid, pkt_data, dct_count, second);
    end
    step(0, 2'b00, 1, 0, 1, 0);
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b, want v=0", pkt_valid);
    end
  endtask

  task automatic test_flush_pending();
    logic [29:0] part;
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 2'b10, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'($urandom_range(1, 3)), 1, 0, 0, 0);
    part = pack(mq);
    step(0, 2'b00, 1, 1, 0, 0);
    repeat (3) step(0, 2'b00, 1, 0, 0, 0);
    checks++;
    if (dct_count !== 4'd4 || pkt_data[33:30] !== 4'd15) begin
      errors++;
      $display("FAIL pend_hold: got cnt=%0d pktcnt=%0d, want cnt=4 pktcnt=15",
               dct_count, pkt_data[33:30]);
    end
    step(0, 2'b00, 1, 0, 1, 0);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_data !== {4'd4, part} || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL pend_emit: got v=%b data=%h cnt=%0d, want v=1 data=%h cnt=0",
               pkt_valid, pkt_data, dct_count, {4'd4, part});
    end
  endtask

  task automatic test_disable();
    logic [29:0] part;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2'($urandom_range(1, 3)), 1, 0, 1, 0);
    step(1, 2'b00, 1, 0, 1, 0);
    checks++;
    if (dct_count !== 4'd5) begin
      errors++;
      $display("FAIL code00_ignored: got cnt=%0d, want 5", dct_count);
    end
    part = pack(mq);
    step(1, 2'b01, 0, 0, 1, 0);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_data !== {4'd5, part} || dct_count !== 4'd0) begin
      errors++;
      $display("FAIL disable_flush: got v=%b data=%h cnt=%0d, want v=1 data=%h cnt=0",
               pkt_valid, pkt_data, dct_count, {4'd5, part});
    end
    repeat (4) step(1, 2'b11, 0, 0, 1, 0);
    checks++;
    if (dct_count !== 4'd0 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_codes: got cnt=%0d v=%b, want 0 0", dct_count, pkt_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 2'b01, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 2'b11, 1, 0, 0, 0);
    checks++;
    if (dct_count !== 4'd9 || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got cnt=%0d v=%b, want 9 1", dct_count, pkt_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dct_buffer, dct_count, pkt_valid, pkt_data, overflow, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_async: got buf=%h cnt=%0d v=%b data=%h, want all 0",
               dct_buffer, dct_count, pkt_valid, pkt_data);
    end
    do_reset();
  endtask

  task automatic test_overflow_clr();
    do_reset();
    for (int i = 0; i < 30; i++) step(1, 2'b01, 1, 0, 0, 0);
    step(1, 2'b10, 1, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b drops=%0d, want 1 1", overflow, drop_count);
    end
    step(1, 2'b10, 1, 0, 0, 1);
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL clr_priority: got ovf=%b drops=%0d, want 0 0", overflow, drop_count);
    end
    for (int i = 0; i < 300; i++) step(1, 2'b11, 1, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got ovf=%b drops=%0d, want 1 255", overflow, drop_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0));
      checks++;
      if (dct_buffer !== pack(mq) || dct_count !== 4'(mq.size()) ||
          pkt_valid !== m_valid || pkt_data !== m_data ||
          overflow !== m_ovf || drop_count !== 8'(m_drops)) begin
        errors++;
        $display("FAIL random_cycle%0d: got buf=%h cnt=%0d v=%b data=%h ovf=%b drops=%0d, want buf=%h cnt=%0d v=%b data=%h ovf=%b drops=%0d",
                 i, dct_buffer, dct_count, pkt_valid, pkt_data, overflow, drop_count,
                 pack(mq), mq.size(), m_valid, m_data, m_ovf, m_drops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_flush_pending();
    test_disable();
    test_reset_mid();
    test_overflow_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
